wrr_pop_scheduler: RTL and testbench

// - Weighted round-robin scheduler that drains NUM_REQ input FIFOs into one shared output path.
// - Issues one-hot pop strobes to the FIFOs and drives the mux select/valid for the downstream datapath.
// - Honours downstream backpressure (dest_almost_full).
// - Grants are held for up to a per-requester weight of consecutive pops.

---
 rtl/wrr_pop_scheduler_if.sv | 34 +++
 rtl/wrr_pop_scheduler.sv | 161 ++++++++++++++++
 tb/tb_wrr_pop_scheduler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wrr_pop_scheduler_if.sv
// Request/pop/mux/config/stats bundle for wrr_pop_scheduler.
// master = FIFO side and config host, slave = the scheduler.
interface wrr_pop_scheduler_if #(
  parameter int NUM_REQ  = 4,
  parameter int SEL_W    = 2,
  parameter int WEIGHT_W = 4
);
  logic [NUM_REQ-1:0]  fifo_empty;
  logic                dest_almost_full;
  logic                cfg_we;
  logic [SEL_W-1:0]    cfg_idx;
  logic [WEIGHT_W-1:0] cfg_weight;
  logic [NUM_REQ-1:0]  pop;
  logic [SEL_W-1:0]    mux_sel;
  logic                mux_valid;
  logic [SEL_W-1:0]    stat_idx;
  logic [15:0]         stat_count;

  modport master (
    output fifo_empty, dest_almost_full,
    output cfg_we, cfg_idx, cfg_weight,
    output stat_idx,
    input  pop, mux_sel, mux_valid,
    input  stat_count
  );

  modport slave (
    input  fifo_empty, dest_almost_full,
    input  cfg_we, cfg_idx, cfg_weight,
    input  stat_idx,
    output pop, mux_sel, mux_valid,
    output stat_count
  );
endinterface

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler draining NUM_REQ FIFOs.
// Define WRR_POP_STATS_EN for per-requester saturating pop counters.
module wrr_pop_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int SEL_W    = 2,
  parameter int WEIGHT_W = 4
) (
  input logic               clk,
  input logic               reset,
  wrr_pop_scheduler_if.slave io
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    STALL = 2'b10
  } state_e;

  state_e              state_q;
  logic [SEL_W-1:0]    winner_q;
  logic [SEL_W-1:0]    ptr_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic [SEL_W-1:0]    mux_sel_q;
  logic                mux_valid_q;
  logic [WEIGHT_W-1:0] weight_q [NUM_REQ];

  logic [NUM_REQ-1:0]  req;
  logic                bp;
  logic                win_req;
  logic [NUM_REQ-1:0]  pop;
  logic [SEL_W-1:0]    nxt_win;
  logic [SEL_W-1:0]    after_win;
  logic [WEIGHT_W-1:0] load_credit;

  assign req     = ~io.fifo_empty;
  assign bp      = io.dest_almost_full;
  assign win_req = req[winner_q];

  // First requester at or after ptr, wrapping
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    nxt_win = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        nxt_win = SEL_W'(idx);
        found   = 1'b1;
      end
    end
  end

  assign after_win = (int'(winner_q) == NUM_REQ - 1)
                   ? '0
                   : winner_q + SEL_W'(1);

  assign load_credit = (weight_q[nxt_win] == '0)
                     ? WEIGHT_W'(1)
                     : weight_q[nxt_win];

  always_comb begin
    pop = '0;
    if (state_q == GRANT && win_req && !bp && !reset)
      pop[winner_q] = 1'b1;
  end

  assign io.pop       = pop;
  assign io.mux_sel   = mux_sel_q;
  assign io.mux_valid = mux_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      winner_q    <= '0;
      ptr_q       <= '0;
      credit_q    <= '0;
      mux_sel_q   <= '0;
      mux_valid_q <= 1'b0;
    end else begin
      mux_valid_q <= |pop;
      if (|pop)
        mux_sel_q <= winner_q;
      unique case (state_q)
        IDLE: begin
          if (|req && !bp) begin
            winner_q <= nxt_win;
            credit_q <= load_credit;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          if (!win_req) begin
            ptr_q   <= after_win;
            state_q <= IDLE;
          end else if (bp) begin
            state_q <= STALL;
          end else begin
            credit_q <= credit_q - WEIGHT_W'(1);
            if (credit_q == WEIGHT_W'(1)) begin
              ptr_q   <= after_win;
              state_q <= IDLE;
            end
          end
        end
        STALL: begin
          if (!win_req) begin
            ptr_q   <= after_win;
            state_q <= IDLE;
          end else if (!bp) begin
            state_q <= GRANT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Out-of-range cfg_idx has no matching weight slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++)
        weight_q[i] <= WEIGHT_W'(1);
    end else if (io.cfg_we) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (int'(io.cfg_idx) == i)
          weight_q[i] <= io.cfg_weight;
    end
  end

`ifdef WRR_POP_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] stat_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (pop[i] && cnt_q[i] != 16'hFFFF)
          cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  always_comb begin
    stat_count = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++)
      if (int'(io.stat_idx) == i)
        stat_count = cnt_q[i];
  end

  assign io.stat_count = stat_count;
`else
  logic unused_stat_idx;
  assign unused_stat_idx = ^io.stat_idx;
  assign io.stat_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Bench for wrr_pop_scheduler: directed vectors plus a
// grant/credit model checked on every falling clock edge.
module tb_wrr_pop_scheduler;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int WW = 4;
`ifdef WRR_POP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  wrr_pop_scheduler_if #(
    .NUM_REQ(N), .SEL_W(SW), .WEIGHT_W(WW)
  ) bus ();

  wrr_pop_scheduler #(
    .NUM_REQ(N), .SEL_W(SW), .WEIGHT_W(WW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  // Model: holder + remaining pops, stalled flag
  bit m_busy, m_stall, m_mv;
  int m_who, m_left, m_ptr, m_ms;
  int m_w   [N];
  int m_cnt [N];

  function automatic void m_reset();
    m_busy  = 1'b0;
    m_stall = 1'b0;
    m_mv    = 1'b0;
    m_who   = 0;
    m_left  = 0;
    m_ptr   = 0;
    m_ms    = 0;
    for (int i = 0; i < N; i++) begin
      m_w[i]   = 1;
      m_cnt[i] = 0;
    end
  endfunction

  always @(negedge clk) begin : cmp_p
    logic [N-1:0] rq;
    logic [N-1:0] ep;
    bit           daf;
    int           c;
    if (reset) begin
      m_reset();
      chk("rst_pop", bus.pop, 0);
      chk("rst_valid", bus.mux_valid, 0);
      chk("rst_sel", bus.mux_sel, 0);
    end else begin
      rq  = ~bus.fifo_empty;
      daf = bus.dest_almost_full;
      ep  = '0;
      if (m_busy && !m_stall && rq[m_who] && !daf)
        ep[m_who] = 1'b1;
      chk("pop", bus.pop, ep);
      chk("mux_valid", bus.mux_valid, m_mv);
      chk("mux_sel", bus.mux_sel, m_ms);
      c = m_cnt[bus.stat_idx];
      if (c > 65535) c = 65535;
      chk("stat_count", bus.stat_count, STATS ? c : 0);
      m_mv = |ep;
      if (|ep) begin
        m_ms = m_who;
        m_cnt[m_who]++;
      end
      if (!m_busy) begin
        if (|rq && !daf) begin
          for (int k = 0; k < N; k++)
            if (rq[(m_ptr + k) % N]) begin
              m_who = (m_ptr + k) % N;
              break;
            end
          m_left  = (m_w[m_who] == 0) ? 1 : m_w[m_who];
          m_busy  = 1'b1;
          m_stall = 1'b0;
        end
      end else if (!rq[m_who]) begin
        m_ptr  = (m_who + 1) % N;
        m_busy = 1'b0;
      end else if (m_stall) begin
        if (!daf) m_stall = 1'b0;
      end else if (daf) begin
        m_stall = 1'b1;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_ptr  = (m_who + 1) % N;
          m_busy = 1'b0;
        end
      end
      if (bus.cfg_we && int'(bus.cfg_idx) < N)
        m_w[bus.cfg_idx] = int'(bus.cfg_weight);
    end
  end

  // Directed vectors: per step inputs and expected pop
  logic [N-1:0] v_fe  [32];
  logic         v_daf [32];
  logic [N-1:0] v_pop [32];
  int           v_n;

  task automatic tick();
    @(posedge clk);
    #1;
    bus.stat_idx = bus.stat_idx + SW'(1);
  endtask

  task automatic add(logic [N-1:0] fe, logic daf,
                     logic [N-1:0] p);
    v_fe[v_n]  = fe;
    v_daf[v_n] = daf;
    v_pop[v_n] = p;
    v_n++;
  endtask

  task automatic run_vec(string nm);
    for (int k = 0; k < v_n; k++) begin
      if (k > 0) tick();
      bus.fifo_empty       = v_fe[k];
      bus.dest_almost_full = v_daf[k];
      #1;
      chk($sformatf("%s[%0d]", nm, k), bus.pop, v_pop[k]);
    end
    v_n = 0;
  endtask

  task automatic do_reset();
    tick();
    reset                = 1'b1;
    bus.fifo_empty       = '1;
    bus.dest_almost_full = 1'b0;
    bus.cfg_we           = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg(int idx, int w);
    bus.cfg_we     = 1'b1;
    bus.cfg_idx    = SW'(idx);
    bus.cfg_weight = WW'(w);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int got;
    int cyc;
    v_n                  = 0;
    bus.fifo_empty       = '1;
    bus.dest_almost_full = 1'b0;
    bus.cfg_we           = 1'b0;
    bus.cfg_idx          = '0;
    bus.cfg_weight       = '0;
    bus.stat_idx         = '0;

    // 1: all requesting, weights 1 -> 0,1,2,3 with bubbles
    do_reset();
    chk("t1_rst_valid", bus.mux_valid, 0);
    add(4'h0, 0, 4'h0); add(4'h0, 0, 4'h1);
    add(4'h0, 0, 4'h0); add(4'h0, 0, 4'h2);
    add(4'h0, 0, 4'h0); add(4'h0, 0, 4'h4);
    add(4'h0, 0, 4'h0); add(4'h0, 0, 4'h8);
    add(4'h0, 0, 4'h0); add(4'h0, 0, 4'h1);
    run_vec("t1_pop");
    chk("t1_sel_hold", bus.mux_sel, 3);
    chk("t1_valid_lo", bus.mux_valid, 0);
    tick();
    chk("t1_valid_hi", bus.mux_valid, 1);
    chk("t1_sel_0", bus.mux_sel, 0);

    // 2: w0=3, w1=0 (loads as 1), FIFOs 0,1 only
    do_reset();
    cfg(0, 3);
    cfg(1, 0);
    for (int r = 0; r < 2; r++) begin
      add(4'hC, 0, 4'h0); add(4'hC, 0, 4'h1);
      add(4'hC, 0, 4'h1); add(4'hC, 0, 4'h1);
      add(4'hC, 0, 4'h0); add(4'hC, 0, 4'h2);
    end
    run_vec("t2_pop");

    // 3: backpressure after 2 of 3 pops on FIFO0
    do_reset();
    cfg(0, 3);
    add(4'hC, 0, 4'h0); add(4'hC, 0, 4'h1);
    add(4'hC, 0, 4'h1); add(4'hC, 1, 4'h0);
    add(4'hC, 1, 4'h0); add(4'hC, 0, 4'h0);
    add(4'hC, 0, 4'h1); add(4'hC, 0, 4'h0);
    add(4'hC, 0, 4'h2);
    run_vec("t3_pop");

    // 4: FIFO3 empties with 5 credits left, ptr wraps to 0
    do_reset();
    cfg(3, 7);
    add(4'h7, 0, 4'h0); add(4'h7, 0, 4'h8);
    add(4'h7, 0, 4'h8); add(4'hC, 0, 4'h0);
    add(4'hC, 0, 4'h0); add(4'hC, 0, 4'h1);
    add(4'hC, 0, 4'h0); add(4'hC, 0, 4'h2);
    run_vec("t4_pop");

    // 5: reset while popping; weights back to 1
    do_reset();
    cfg(0, 4);
    cfg(2, 5);
    add(4'h0, 0, 4'h0); add(4'h0, 0, 4'h1);
    add(4'h0, 0, 4'h1);
    run_vec("t5_pre");
    chk("t5_pre_valid", bus.mux_valid, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_pop", bus.pop, 0);
    chk("t5_rst_valid", bus.mux_valid, 0);
    tick();
    tick();
    reset = 1'b0;
    add(4'h0, 0, 4'h0); add(4'h0, 0, 4'h1);
    add(4'h0, 0, 4'h0); add(4'h0, 0, 4'h2);
    add(4'h0, 0, 4'h0); add(4'h0, 0, 4'h4);
    add(4'h0, 0, 4'h0);
    run_vec("t5_post");

    // 6: statistics
`ifdef WRR_POP_STATS_EN
    do_reset();
    cfg(2, 15);
    bus.fifo_empty = 4'hB;
    got = 0;
    cyc = 0;
    while (got < 70000 && cyc < 80000) begin
      tick();
      if (bus.pop[2]) got++;
      cyc++;
    end
    chk("t6_pops", got, 70000);
    bus.stat_idx = 2;
    #1;
    chk("t6_sat", bus.stat_count, 16'hFFFF);
    bus.stat_idx = 0;
    #1;
    chk("t6_other", bus.stat_count, 0);
`else
    got = 0;
    cyc = 0;
    bus.stat_idx = 2;
    #1;
    chk("t6_zero2", bus.stat_count, 0);
    bus.stat_idx = 0;
    #1;
    chk("t6_zero0", bus.stat_count, 0);
`endif
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
